// File: rtl/fgen_sweep_sched_if.sv
// rtl/fgen_sweep_sched_if.sv - host configuration request channel for the sweep scheduler
interface fgen_sweep_sched_if #(
   parameter int CNT_W = 32
);
   logic             host_valid;
   logic             host_ready;
   logic [2:0]       host_sig_type;
   logic [CNT_W-1:0] host_count;
   logic [7:0]       host_duty;
   logic [15:0]      host_pattern;

   modport master (
      output host_valid, host_sig_type, host_count, host_duty, host_pattern,
      input  host_ready
   );

   modport slave (
      input  host_valid, host_sig_type, host_count, host_duty, host_pattern,
      output host_ready
   );
endinterface

// File: rtl/fgen_sweep_sched.sv
// rtl/fgen_sweep_sched.sv - arbitrates host config writes against a count sweep and range-checks both
module fgen_sweep_sched #(
   parameter int CNT_W     = 32,
   parameter int SINE_MAX  = 9999,
   parameter int SQPWM_MAX = 499999,
   parameter int PAT_MAX   = 62499
) (
   input  logic             clk,
   input  logic             rst_n,
   fgen_sweep_sched_if.slave host,
   input  logic             sweep_start,
   input  logic             sweep_abort,
   input  logic [CNT_W-1:0] sw_start_cnt,
   input  logic [CNT_W-1:0] sw_stop_cnt,
   input  logic [CNT_W-1:0] sw_step,
   input  logic [CNT_W-1:0] sw_dwell,
   output logic [2:0]       sig_type,
   output logic [CNT_W-1:0] set_count,
   output logic [7:0]       duty_cycle,
   output logic [15:0]      pattern,
   output logic             cfg_update,
   output logic             busy,
   output logic             sweep_done,
   output logic             err_range
);
   typedef enum logic [1:0] {S_IDLE, S_DWELL, S_STEP} state_t;

   state_t           state_q;
   logic [CNT_W-1:0] dcnt_q;
   logic [2:0]       sig_type_q;
   logic [CNT_W-1:0] set_count_q;
   logic [7:0]       duty_q;
   logic [15:0]      pattern_q;
   logic             cfg_update_q;
   logic             busy_q;
   logic             sweep_done_q;
   logic             err_range_q;

   // Caller guarantees t <= 4; illegal types are filtered separately.
   function automatic logic [CNT_W-1:0] lim(input logic [2:0] t);
      case (t)
         3'd0, 3'd1: lim = CNT_W'(SINE_MAX);
         3'd2, 3'd3: lim = CNT_W'(SQPWM_MAX);
         default:    lim = CNT_W'(PAT_MAX);
      endcase
   endfunction

   logic             host_legal;
   logic             sweep_ok;
   logic [CNT_W:0]   nxt_d;
   logic [CNT_W-1:0] dwell_eff;

   assign host_legal = (host.host_sig_type <= 3'd4) &&
                       (host.host_count <= lim(host.host_sig_type));
   assign sweep_ok   = (sw_step != '0) && (sw_start_cnt <= sw_stop_cnt) &&
                       (sw_stop_cnt <= lim(sig_type_q));
   assign nxt_d      = {1'b0, set_count_q} + {1'b0, sw_step};
   assign dwell_eff  = (sw_dwell == '0) ? CNT_W'(1) : sw_dwell;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         dcnt_q       <= '0;
         sig_type_q   <= '0;
         set_count_q  <= CNT_W'(999);
         duty_q       <= '0;
         pattern_q    <= '0;
         cfg_update_q <= 1'b0;
         busy_q       <= 1'b0;
         sweep_done_q <= 1'b0;
         err_range_q  <= 1'b0;
      end else begin
         cfg_update_q <= 1'b0;
         sweep_done_q <= 1'b0;
         err_range_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (host.host_valid) begin
                  if (host_legal) begin
                     sig_type_q   <= host.host_sig_type;
                     set_count_q  <= host.host_count;
                     duty_q       <= host.host_duty;
                     pattern_q    <= host.host_pattern;
                     cfg_update_q <= 1'b1;
                  end else begin
                     err_range_q  <= 1'b1;
                  end
               end else if (sweep_start) begin
                  if (sweep_ok) begin
                     set_count_q  <= sw_start_cnt;
                     cfg_update_q <= 1'b1;
                     busy_q       <= 1'b1;
                     dcnt_q       <= CNT_W'(1);
                     state_q      <= S_DWELL;
                  end else begin
                     err_range_q  <= 1'b1;
                  end
               end
            end
            // dcnt_q counts the clocks the current count has been visible, starting at 1.
            S_DWELL: begin
               if (sweep_abort) begin
                  busy_q  <= 1'b0;
                  dcnt_q  <= '0;
                  state_q <= S_IDLE;
               end else if (dcnt_q >= dwell_eff) begin
                  state_q <= S_STEP;
               end else begin
                  dcnt_q  <= dcnt_q + CNT_W'(1);
               end
            end
            S_STEP: begin
               if (sweep_abort) begin
                  busy_q  <= 1'b0;
                  dcnt_q  <= '0;
                  state_q <= S_IDLE;
               end else if (nxt_d[CNT_W] || (nxt_d[CNT_W-1:0] > sw_stop_cnt)) begin
                  sweep_done_q <= 1'b1;
                  busy_q       <= 1'b0;
                  dcnt_q       <= '0;
                  state_q      <= S_IDLE;
               end else begin
                  set_count_q  <= nxt_d[CNT_W-1:0];
                  cfg_update_q <= 1'b1;
                  dcnt_q       <= CNT_W'(1);
                  state_q      <= S_DWELL;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign host.host_ready = (state_q == S_IDLE);
   assign sig_type        = sig_type_q;
   assign set_count       = set_count_q;
   assign duty_cycle      = duty_q;
   assign pattern         = pattern_q;
   assign cfg_update      = cfg_update_q;
   assign busy            = busy_q;
   assign sweep_done      = sweep_done_q;
   assign err_range       = err_range_q;
endmodule

// File: tb/tb_fgen_sweep_sched.sv
// tb/tb_fgen_sweep_sched.sv - self-checking bench for fgen_sweep_sched
module tb_fgen_sweep_sched;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        sweep_start, sweep_abort;
   logic [31:0] sw_start_cnt, sw_stop_cnt, sw_step, sw_dwell;
   logic [2:0]  sig_type;
   logic [31:0] set_count;
   logic [7:0]  duty_cycle;
   logic [15:0] pattern;
   logic        cfg_update, busy, sweep_done, err_range;

   fgen_sweep_sched_if #(.CNT_W(32)) hif ();

   fgen_sweep_sched dut (
      .clk(clk), .rst_n(rst_n), .host(hif),
      .sweep_start(sweep_start), .sweep_abort(sweep_abort),
      .sw_start_cnt(sw_start_cnt), .sw_stop_cnt(sw_stop_cnt),
      .sw_step(sw_step), .sw_dwell(sw_dwell),
      .sig_type(sig_type), .set_count(set_count), .duty_cycle(duty_cycle),
      .pattern(pattern), .cfg_update(cfg_update), .busy(busy),
      .sweep_done(sweep_done), .err_range(err_range)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Reference: applied config plus a precomputed list of sweep counts still to visit.
   int       m_type, m_duty, m_pat, m_left, m_dw;
   longint   m_cnt;
   bit       m_busy, m_upd, m_done, m_err;
   longint   m_q[$];

   function automatic longint lim_of(int t);
      if (t <= 1) return 9999;
      if (t <= 3) return 499999;
      return 62499;
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic model_edge();
      int t;
      longint c, st, sp, stp;
      m_upd = 0; m_done = 0; m_err = 0;
      if (!rst_n) begin
         m_type = 0; m_cnt = 999; m_duty = 0; m_pat = 0; m_busy = 0; m_q.delete();
      end else if (!m_busy) begin
         if (hif.host_valid) begin
            t = int'(hif.host_sig_type);
            c = longint'(hif.host_count);
            if (t <= 4 && c <= lim_of(t)) begin
               m_type = t; m_cnt = c; m_duty = int'(hif.host_duty);
               m_pat = int'(hif.host_pattern); m_upd = 1;
            end else m_err = 1;
         end else if (sweep_start) begin
            st = longint'(sw_start_cnt); sp = longint'(sw_stop_cnt); stp = longint'(sw_step);
            if (stp == 0 || st > sp || sp > lim_of(m_type)) m_err = 1;
            else begin
               m_q.delete();
               for (longint s = st; s <= sp; s += stp) m_q.push_back(s);
               m_cnt  = m_q.pop_front();
               m_dw   = (sw_dwell == 0) ? 1 : int'(sw_dwell);
               m_left = m_dw + 1;
               m_busy = 1; m_upd = 1;
            end
         end
      end else if (sweep_abort) begin
         m_busy = 0; m_q.delete();
      end else begin
         m_left--;
         if (m_left == 0) begin
            if (m_q.size() == 0) begin
               m_done = 1; m_busy = 0;
            end else begin
               m_cnt = m_q.pop_front(); m_upd = 1; m_left = m_dw + 1;
            end
         end
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      chk("sig_type", 64'(sig_type), 64'(m_type));
      chk("set_count", 64'(set_count), 64'(m_cnt));
      chk("duty_cycle", 64'(duty_cycle), 64'(m_duty));
      chk("pattern", 64'(pattern), 64'(m_pat));
      chk("cfg_update", 64'(cfg_update), 64'(m_upd));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("sweep_done", 64'(sweep_done), 64'(m_done));
      chk("err_range", 64'(err_range), 64'(m_err));
      chk("host_ready", 64'(hif.host_ready), 64'(!m_busy));
   endtask

   task automatic host_set(bit v, int t, longint c, int d, int p);
      hif.host_valid = v; hif.host_sig_type = 3'(t); hif.host_count = 32'(c);
      hif.host_duty = 8'(d); hif.host_pattern = 16'(p);
   endtask

   task automatic sweep_cfg(longint st, longint sp, longint stp, longint dw);
      sw_start_cnt = 32'(st); sw_stop_cnt = 32'(sp); sw_step = 32'(stp); sw_dwell = 32'(dw);
   endtask

   typedef struct {
      int     t;
      longint c;
      bit     e_upd;
      bit     e_err;
      int     e_type;
      longint e_cnt;
   } hvec_t;

   hvec_t tbl[10];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      longint trace[$];
      int done_n, done_at;

      tbl[0] = '{2, 499999, 1, 0, 2, 499999};
      tbl[1] = '{2, 500000, 0, 1, 2, 499999};
      tbl[2] = '{5, 5,      0, 1, 2, 499999};
      tbl[3] = '{0, 9999,   1, 0, 0, 9999};
      tbl[4] = '{1, 10000,  0, 1, 0, 9999};
      tbl[5] = '{4, 62499,  1, 0, 4, 62499};
      tbl[6] = '{4, 62500,  0, 1, 4, 62499};
      tbl[7] = '{3, 0,      1, 0, 3, 0};
      tbl[8] = '{7, 0,      0, 1, 3, 0};
      tbl[9] = '{0, 100,    1, 0, 0, 100};

      rst_n = 1'b0; sweep_start = 0; sweep_abort = 0;
      host_set(0, 0, 0, 0, 0);
      sweep_cfg(0, 0, 0, 0);
      tick(); tick();
      rst_n = 1'b1;
      tick();
      chk("reset_count", 64'(set_count), 64'd999);
      chk("reset_busy", 64'(busy), 64'd0);

      for (int i = 0; i < 10; i++) begin
         host_set(1, tbl[i].t, tbl[i].c, 3 * i + 1, 16'h1234 + i);
         tick();
         chk($sformatf("vec%0d_upd", i), 64'(cfg_update), 64'(tbl[i].e_upd));
         chk($sformatf("vec%0d_err", i), 64'(err_range), 64'(tbl[i].e_err));
         chk($sformatf("vec%0d_type", i), 64'(sig_type), 64'(tbl[i].e_type));
         chk($sformatf("vec%0d_cnt", i), 64'(set_count), 64'(tbl[i].e_cnt));
      end
      host_set(0, 0, 0, 0, 0);
      tick();

      // Sweep 100..130 step 10 dwell 3
      sweep_cfg(100, 130, 10, 3);
      sweep_start = 1; tick(); sweep_start = 0;
      trace.delete(); done_n = 0; done_at = -1;
      if (cfg_update) trace.push_back(longint'(set_count));
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (cfg_update) trace.push_back(longint'(set_count));
         if (sweep_done) begin done_n++; done_at = i; end
      end
      chk("sweep_updates", 64'(trace.size()), 64'd4);
      for (int i = 0; i < trace.size() && i < 4; i++)
         chk($sformatf("sweep_val%0d", i), 64'(trace[i]), 64'(100 + 10 * i));
      chk("sweep_done_n", 64'(done_n), 64'd1);
      chk("sweep_done_at", 64'(done_at), 64'd16);
      chk("sweep_busy_after", 64'(busy), 64'd0);

      // Rejected sweeps
      sweep_cfg(100, 130, 0, 3);
      sweep_start = 1; tick(); sweep_start = 0;
      chk("step0_err", 64'(err_range), 64'd1);
      chk("step0_busy", 64'(busy), 64'd0);
      sweep_cfg(200, 100, 10, 3);
      sweep_start = 1; tick(); sweep_start = 0;
      chk("order_err", 64'(err_range), 64'd1);
      sweep_cfg(9990, 10000, 5, 1);
      sweep_start = 1; tick(); sweep_start = 0;
      chk("lim_err", 64'(err_range), 64'd1);

      // Abort during the 110 dwell, host held off while busy
      sweep_cfg(100, 130, 10, 3);
      sweep_start = 1; tick(); sweep_start = 0;
      for (int i = 0; i < 4; i++) tick();
      chk("abort_pre_cnt", 64'(set_count), 64'd110);
      host_set(1, 0, 55, 9, 9);
      tick();
      chk("busy_host_ready", 64'(hif.host_ready), 64'd0);
      sweep_abort = 1; tick(); sweep_abort = 0;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_cnt", 64'(set_count), 64'd110);
      chk("abort_no_done", 64'(sweep_done), 64'd0);
      tick();
      chk("post_abort_host", 64'(set_count), 64'd55);
      host_set(0, 0, 0, 0, 0);
      tick();

      // Host beats same-cycle sweep_start
      sweep_cfg(10, 30, 5, 2);
      host_set(1, 0, 77, 1, 2);
      sweep_start = 1; tick(); sweep_start = 0;
      host_set(0, 0, 0, 0, 0);
      chk("arb_cnt", 64'(set_count), 64'd77);
      chk("arb_busy", 64'(busy), 64'd0);

      // Reset mid-sweep
      sweep_start = 1; tick(); sweep_start = 0;
      tick(); tick(); tick();
      rst_n = 0; tick(); rst_n = 1;
      chk("rst_cnt", 64'(set_count), 64'd999);
      chk("rst_busy", 64'(busy), 64'd0);
      tick();

      // Randomized traffic
      for (int n = 0; n < 1500; n++) begin
         int t, mode;
         longint c;
         rst_n = ($urandom_range(0, 199) != 0);
         t = $urandom_range(0, 7);
         mode = $urandom_range(0, 3);
         if (mode == 0) c = lim_of(t > 4 ? 4 : t) - 1 + $urandom_range(0, 2);
         else if (mode == 1) c = longint'($urandom);
         else c = $urandom_range(0, 200);
         host_set($urandom_range(0, 5) == 0, t, c, $urandom_range(0, 255), $urandom_range(0, 65535));
         sweep_start = ($urandom_range(0, 4) == 0);
         sweep_abort = ($urandom_range(0, 39) == 0);
         if (!m_busy) begin
            longint st;
            st = $urandom_range(0, 60);
            if ($urandom_range(0, 9) == 0) st = 9980;
            sweep_cfg(st, st + $urandom_range(0, 80) - ($urandom_range(0, 7) == 0 ? 90 : 0),
                      ($urandom_range(0, 9) == 0) ? 64'hFFFF_FF00 + $urandom_range(0, 255)
                                                  : longint'($urandom_range(0, 25)),
                      $urandom_range(0, 3));
         end
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
